// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC sequencer: state encoding and default sizing.
package adc_seq_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_CH   = 8;
  localparam int DEF_CONV_CYC = 4;
  localparam int DEF_RD_CYC   = 2;
  localparam int DEF_TIMEOUT  = 255;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CONV      = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_READ      = 3'd3;
  localparam logic [2:0] ST_OUT       = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_CONV      = ST_CONV,
    S_WAIT_BUSY = ST_WAIT_BUSY,
    S_READ      = ST_READ,
    S_OUT       = ST_OUT,
    S_DONE      = ST_DONE
  } state_e;

  // Largest of three values, used to size the shared cycle counter.
  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/adc_seq_ctrl_start_edge.sv
// START rising-edge detector. An edge only counts once START has been seen low
// since reset, so a trigger already high when reset releases cannot launch.
module start_edge (
  input  logic CLK,
  input  logic RST_N,
  input  logic start_i,
  output logic edge_o
);

  logic start_q;
  logic armed_q;

  // Remember last START level and arm the detector after the first low sample.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      start_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      start_q <= start_i;
      if (!start_i) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign edge_o = start_i & ~start_q & armed_q;

endmodule

// File: rtl/adc_seq_ctrl.sv
// Sequencer for a parallel-output ADC: converts and reads NUM_CH samples per
// START edge and streams them out with a valid/ready handshake.
module adc_seq_ctrl
  import adc_seq_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CONV_CYC = DEF_CONV_CYC,
  parameter int RD_CYC   = DEF_RD_CYC,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  localparam int CH_W    = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              ADC_BUSY,
  input  logic [DATA_W-1:0] ADC_DATA,
  output logic              ADC_CONVST,
  output logic              ADC_CS_N,
  output logic              ADC_RD_N,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DATA_W-1:0] M_DATA,
  output logic [CH_W-1:0]   M_CH,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int CNT_MAX = maxOf3(CONV_CYC, RD_CYC, TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cycCnt_q, cycCnt_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              startEdge;

  start_edge uStartEdge (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .start_i (START),
    .edge_o  (startEdge)
  );

  // State, counters, captured sample and error flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      cycCnt_q <= '0;
      chan_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycCnt_q <= cycCnt_d;
      chan_q   <= chan_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic and converter/stream controls decoded from the state.
  always_comb begin
    state_d    = state_q;
    cycCnt_d   = cycCnt_q;
    chan_d     = chan_q;
    data_d     = data_q;
    err_d      = err_q;
    ADC_CONVST = 1'b0;
    ADC_CS_N   = 1'b1;
    ADC_RD_N   = 1'b1;
    M_VALID    = 1'b0;
    BUSY       = 1'b1;
    DONE       = 1'b0;

    case (state_q)
      S_IDLE: begin
        BUSY = 1'b0;
        if (startEdge) begin
          state_d  = S_CONV;
          cycCnt_d = '0;
          chan_d   = '0;
          err_d    = 1'b0;
        end
      end

      S_CONV: begin
        ADC_CONVST = 1'b1;
        if (cycCnt_q == CONV_LAST) begin
          state_d  = S_WAIT_BUSY;
          cycCnt_d = '0;
        end else begin
          cycCnt_d = cycCnt_q + CNT_W'(1);
        end
      end

      S_WAIT_BUSY: begin
        if (!ADC_BUSY) begin
          state_d  = S_READ;
          cycCnt_d = '0;
        end else if (cycCnt_q == TO_LAST) begin
          state_d  = S_DONE;
          cycCnt_d = '0;
          err_d    = 1'b1;
        end else begin
          cycCnt_d = cycCnt_q + CNT_W'(1);
        end
      end

      S_READ: begin
        ADC_CS_N = 1'b0;
        ADC_RD_N = 1'b0;
        if (cycCnt_q == RD_LAST) begin
          data_d   = ADC_DATA;
          state_d  = S_OUT;
          cycCnt_d = '0;
        end else begin
          cycCnt_d = cycCnt_q + CNT_W'(1);
        end
      end

      S_OUT: begin
        ADC_CS_N = 1'b0;
        M_VALID  = 1'b1;
        if (M_READY) begin
          if (chan_q == CH_LAST) begin
            state_d = S_DONE;
          end else begin
            chan_d  = chan_q + CH_W'(1);
            state_d = S_READ;
          end
        end
      end

      S_DONE: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign M_DATA = data_q;
  assign M_CH   = chan_q;
  assign ERR    = err_q;

endmodule
